// File: rtl/sii_ncu_xfer_chk_if.sv
// SII->NCU inbound bus bundle observed by the transfer checker.
//   sii_ncu_req     : per-channel request pulse (one per packet offered)
//   ncu_sii_gnt     : per-channel grant pulse
//   sii_ncu_data    : shared data bus (header beat, then payload beats)
//   sii_ncu_dparity : even parity, bit i covers data[16i+15:16i]
// master = the side driving the bus (or a testbench), slave = the checker.
interface sii_ncu_xfer_chk_if #(
    parameter int NUM_CH = 2,
    parameter int DW     = 32
) ();
    logic [NUM_CH-1:0] sii_ncu_req;
    logic [NUM_CH-1:0] ncu_sii_gnt;
    logic [DW-1:0]     sii_ncu_data;
    logic [DW/16-1:0]  sii_ncu_dparity;

    modport master (output sii_ncu_req, ncu_sii_gnt, sii_ncu_data, sii_ncu_dparity);
    modport slave  (input  sii_ncu_req, ncu_sii_gnt, sii_ncu_data, sii_ncu_dparity);
endinterface

// File: rtl/sii_ncu_xfer_chk.sv
// Inbound SII->NCU transfer checker (iol2clk domain).
// Tracks per-channel request/grant credits and grant wait time, captures one
// header beat plus PAYLOAD_BEATS payload beats per grant, checks per-lane
// payload parity, counts completed transfers and raises sticky errors.
// Ports:
//   iol2clk, rst_l (async active-low), mon_en (low = flush tracking state)
//   bus         : request/grant/data/parity bundle (slave modport)
//   err_clr     : clears sticky error flags (a same-cycle new event wins)
//   xfer_vld    : one-cycle pulse when a transfer completes
//   xfer_ch/xfer_hdr/xfer_perr : details of the last completed transfer (held)
//   xfer_cnt    : completed transfer count, wraps
//   err_parity/err_proto/err_timeout : sticky error flags
module sii_ncu_xfer_chk #(
    parameter int NUM_CH        = 2,
    parameter int DW            = 32,
    parameter int PAYLOAD_BEATS = 4,
    parameter int MAX_OUT       = 4,
    parameter int TIMEOUT       = 256,
    parameter int CNT_W         = 16,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              iol2clk,
    input  logic              rst_l,
    input  logic              mon_en,
    input  logic              err_clr,
    sii_ncu_xfer_chk_if.slave bus,
    output logic              xfer_vld,
    output logic [CH_W-1:0]   xfer_ch,
    output logic [DW-1:0]     xfer_hdr,
    output logic              xfer_perr,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              err_parity,
    output logic              err_proto,
    output logic              err_timeout
);
    localparam int NL = DW / 16;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int BW = (PAYLOAD_BEATS > 1) ? $clog2(PAYLOAD_BEATS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [DW-1:0]             hdr_q, hdr_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic                      perr_q, perr_d;
    logic [NUM_CH-1:0][OW-1:0] out_cnt_q, out_cnt_d;
    logic [NUM_CH-1:0][WW-1:0] wait_cnt_q, wait_cnt_d;
    logic                      xfer_vld_q, xfer_vld_d;
    logic [CH_W-1:0]           xfer_ch_q, xfer_ch_d;
    logic [DW-1:0]             xfer_hdr_q, xfer_hdr_d;
    logic                      xfer_perr_q, xfer_perr_d;
    logic [CNT_W-1:0]          xfer_cnt_q, xfer_cnt_d;
    logic                      err_parity_q, err_parity_d;
    logic                      err_proto_q, err_proto_d;
    logic                      err_timeout_q, err_timeout_d;

    logic [NUM_CH-1:0] req, gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any, gnt_multi, gnt_one, lane_err, last_beat;
    logic              par_ev, proto_ev, to_ev;

    // With the monitor disabled, req/gnt are invisible to every tracker.
    assign req       = mon_en ? bus.sii_ncu_req : '0;
    assign gnt       = mon_en ? bus.ncu_sii_gnt : '0;
    assign gnt_any   = |gnt;
    assign gnt_multi = |(gnt & (gnt - NUM_CH'(1)));
    assign gnt_one   = gnt_any && !gnt_multi;
    assign last_beat = (state_q == PAY) && (beat_q == BW'(PAYLOAD_BEATS - 1));

    always_comb begin
        gnt_idx  = '0;
        lane_err = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (gnt[c]) gnt_idx = CH_W'(c);
        for (int i = 0; i < NL; i++)
            lane_err = lane_err | (bus.sii_ncu_dparity[i] ^ (^bus.sii_ncu_data[16*i +: 16]));
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        hdr_d       = hdr_q;
        beat_d      = beat_q;
        perr_d      = perr_q;
        out_cnt_d   = out_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        xfer_vld_d  = 1'b0;
        xfer_ch_d   = xfer_ch_q;
        xfer_hdr_d  = xfer_hdr_q;
        xfer_perr_d = xfer_perr_q;
        xfer_cnt_d  = xfer_cnt_q;
        par_ev      = 1'b0;
        to_ev       = 1'b0;
        // A grant while the shared bus is busy (anything but the last beat)
        // collides with the transfer in flight.
        proto_ev    = gnt_multi ||
                      (gnt_any && (state_q == HDR || (state_q == PAY && !last_beat)));

        for (int c = 0; c < NUM_CH; c++) begin
            if (!mon_en) begin
                out_cnt_d[c] = '0;
            end else if (req[c] && !gnt[c]) begin
                if (out_cnt_q[c] == OW'(MAX_OUT)) proto_ev = 1'b1;
                else out_cnt_d[c] = out_cnt_q[c] + OW'(1);
            end else if (gnt[c] && !req[c]) begin
                if (out_cnt_q[c] == '0) proto_ev = 1'b1;
                else out_cnt_d[c] = out_cnt_q[c] - OW'(1);
            end

            // Wait counter saturates at TIMEOUT so an episode flags only once.
            if (!mon_en || gnt[c] || out_cnt_q[c] == '0) begin
                wait_cnt_d[c] = '0;
            end else if (wait_cnt_q[c] != WW'(TIMEOUT)) begin
                wait_cnt_d[c] = wait_cnt_q[c] + WW'(1);
                if (wait_cnt_q[c] == WW'(TIMEOUT - 1)) to_ev = 1'b1;
            end
        end

        if (!mon_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (gnt_one) begin
                    ch_d    = gnt_idx;
                    state_d = HDR;
                end
                HDR: begin
                    hdr_d   = bus.sii_ncu_data;
                    beat_d  = '0;
                    perr_d  = 1'b0;
                    state_d = PAY;
                end
                PAY: begin
                    par_ev = lane_err;
                    perr_d = perr_q | lane_err;
                    beat_d = beat_q + BW'(1);
                    if (last_beat) begin
                        xfer_vld_d  = 1'b1;
                        xfer_ch_d   = ch_q;
                        xfer_hdr_d  = hdr_q;
                        xfer_perr_d = perr_q | lane_err;
                        xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
                        state_d     = gnt_one ? HDR : IDLE;
                        if (gnt_one) ch_d = gnt_idx;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_parity_d  = (err_parity_q  && !err_clr) || par_ev;
        err_proto_d   = (err_proto_q   && !err_clr) || proto_ev;
        err_timeout_d = (err_timeout_q && !err_clr) || to_ev;
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            hdr_q         <= '0;
            beat_q        <= '0;
            perr_q        <= 1'b0;
            out_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            xfer_vld_q    <= 1'b0;
            xfer_ch_q     <= '0;
            xfer_hdr_q    <= '0;
            xfer_perr_q   <= 1'b0;
            xfer_cnt_q    <= '0;
            err_parity_q  <= 1'b0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            hdr_q         <= hdr_d;
            beat_q        <= beat_d;
            perr_q        <= perr_d;
            out_cnt_q     <= out_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            xfer_vld_q    <= xfer_vld_d;
            xfer_ch_q     <= xfer_ch_d;
            xfer_hdr_q    <= xfer_hdr_d;
            xfer_perr_q   <= xfer_perr_d;
            xfer_cnt_q    <= xfer_cnt_d;
            err_parity_q  <= err_parity_d;
            err_proto_q   <= err_proto_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign xfer_vld    = xfer_vld_q;
    assign xfer_ch     = xfer_ch_q;
    assign xfer_hdr    = xfer_hdr_q;
    assign xfer_perr   = xfer_perr_q;
    assign xfer_cnt    = xfer_cnt_q;
    assign err_parity  = err_parity_q;
    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;
endmodule
